// File: rtl/uart_frame_responder.sv
// Byte-framed register-access responder: parses A5/CMD/ADDR/DATA/CHK requests
// from a UART receiver and answers with 5A/STATUS/RDATA/RCHK via a UART transmitter.
module uart_frame_responder #(
    parameter int DATA_SIZE = 8,
    parameter int REG_DEPTH = 16,
    parameter int TIMEOUT   = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_req,
    input  logic [DATA_SIZE-1:0] rx_data,
    output logic                 recv_ack,
    output logic                 send_req,
    input  logic                 send_ack,
    output logic [DATA_SIZE-1:0] tx_data,
    output logic                 frame_done,
    output logic [7:0]           err_count
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]        TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [DATA_SIZE-1:0] HDR_REQ = DATA_SIZE'(8'hA5);
    localparam logic [DATA_SIZE-1:0] HDR_RSP = DATA_SIZE'(8'h5A);
    localparam logic [DATA_SIZE-1:0] CMD_WR  = DATA_SIZE'(8'h01);
    localparam logic [DATA_SIZE-1:0] CMD_RD  = DATA_SIZE'(8'h02);

    typedef enum logic [2:0] {
        IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, SEND, WAIT_ACK
    } state_t;

    state_t               state, state_next;
    logic [DATA_SIZE-1:0] regs [REG_DEPTH];
    logic [DATA_SIZE-1:0] cmd, addr, data, chk;
    logic [DATA_SIZE-1:0] status_q, rdata_q;
    logic [DATA_SIZE-1:0] status_c, rdata_c, resp_byte;
    logic [CW-1:0]        cnt;
    logic [1:0]           idx;
    logic                 get_state, take, timeout_hit, ack_ok;
    logic [AW-1:0]        addr_idx;

    assign addr_idx = addr[AW-1:0];

    always_comb begin
        state_next  = state;
        status_c    = '0;
        rdata_c     = '0;
        resp_byte   = '0;
        get_state   = state inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
        // recv_ack still high means this byte was consumed on the previous edge
        take        = (get_state || state == IDLE) && recv_req && !recv_ack;
        timeout_hit = get_state && !recv_req && cnt == TO_LAST;
        ack_ok      = send_ack && send_req;

        if (chk != (cmd ^ addr ^ data))
            status_c = DATA_SIZE'(8'h01);
        else if (cmd != CMD_WR && cmd != CMD_RD)
            status_c = DATA_SIZE'(8'h02);
        else if ({{(32-DATA_SIZE){1'b0}}, addr} >= 32'(REG_DEPTH))
            status_c = DATA_SIZE'(8'h03);
        if (status_c == '0)
            rdata_c = (cmd == CMD_WR) ? data : regs[addr_idx];

        case (idx)
            2'd0:    resp_byte = HDR_RSP;
            2'd1:    resp_byte = status_q;
            2'd2:    resp_byte = rdata_q;
            default: resp_byte = status_q ^ rdata_q;
        endcase

        case (state)
            IDLE:     if (take && rx_data == HDR_REQ) state_next = GET_CMD;
            GET_CMD:  if (timeout_hit) state_next = IDLE; else if (take) state_next = GET_ADDR;
            GET_ADDR: if (timeout_hit) state_next = IDLE; else if (take) state_next = GET_DATA;
            GET_DATA: if (timeout_hit) state_next = IDLE; else if (take) state_next = GET_CHK;
            GET_CHK:  if (timeout_hit) state_next = IDLE; else if (take) state_next = EXEC;
            EXEC:     state_next = SEND;
            SEND:     state_next = WAIT_ACK;
            WAIT_ACK: if (ack_ok) state_next = (idx == 2'd3) ? IDLE : SEND;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            recv_ack   <= 1'b0;
            send_req   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b0;
            err_count  <= '0;
            cnt        <= '0;
            idx        <= '0;
            cmd        <= '0;
            addr       <= '0;
            data       <= '0;
            chk        <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            state      <= state_next;
            recv_ack   <= take;
            frame_done <= 1'b0;

            if (take) begin
                case (state)
                    GET_CMD:  cmd  <= rx_data;
                    GET_ADDR: addr <= rx_data;
                    GET_DATA: data <= rx_data;
                    GET_CHK:  chk  <= rx_data;
                    default:  ;
                endcase
            end

            if (!get_state || take || timeout_hit)
                cnt <= '0;
            else if (!recv_req)
                cnt <= cnt + 1'b1;

            if ((timeout_hit || (state == EXEC && status_c != '0)) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            case (state)
                EXEC: begin
                    status_q <= status_c;
                    rdata_q  <= rdata_c;
                    idx      <= '0;
                    if (status_c == '0 && cmd == CMD_WR) regs[addr_idx] <= data;
                end
                SEND: begin
                    send_req <= 1'b1;
                    tx_data  <= resp_byte;
                end
                WAIT_ACK: begin
                    if (ack_ok) begin
                        send_req <= 1'b0;
                        idx      <= idx + 2'd1;
                        if (idx == 2'd3) frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_responder.sv
// Self-checking bench for uart_frame_responder: directed vector table, corner
// sequences (timeout, stalled acks, reset aborts, saturation) and random frames.
module tb_uart_frame_responder;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset, recv_req, recv_ack, send_req, send_ack, frame_done;
    logic [7:0] rx_data, tx_data, err_count;

    always #5 clk = ~clk;

    uart_frame_responder #(.DATA_SIZE(8), .REG_DEPTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .recv_req(recv_req), .rx_data(rx_data),
        .recv_ack(recv_ack), .send_req(send_req), .send_ack(send_ack),
        .tx_data(tx_data), .frame_done(frame_done), .err_count(err_count)
    );

    typedef struct {
        bit          rst;
        int          noise;
        logic [7:0]  cmd, addr, data, chk;
        logic [31:0] resp;
        logic [7:0]  err;
    } vec_t;

    vec_t        tbl [13];
    int          n_cmp = 0, n_bad = 0;
    int          stable_bad, gap_bad, ack_seen, done_cnt;
    logic [31:0] resp;
    logic [7:0]  m_regs [16];
    int          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        @(negedge clk);
        rx_data  = b;
        recv_req = 1'b1;
        w = 0;
        while (recv_ack !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (recv_ack !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL recv_wait: byte %02h recv_ack got 0 expected 1", b);
        end
        recv_req = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] c, a, d, k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    task automatic get_resp(input int delay);
        int         w;
        logic [7:0] b;
        resp = '0; stable_bad = 0; gap_bad = 0; ack_seen = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (send_req !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
                if (frame_done) done_cnt++;
                if (recv_ack) ack_seen++;
            end
            if (send_req !== 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_wait: byte %0d send_req got 0 expected 1", i);
                return;
            end
            b    = tx_data;
            resp = {resp[23:0], b};
            for (int d = 0; d < delay; d++) begin
                @(negedge clk);
                if (frame_done) done_cnt++;
                if (recv_ack) ack_seen++;
                if (send_req !== 1'b1 || tx_data !== b) stable_bad++;
            end
            send_ack = 1'b1;
            @(negedge clk);
            send_ack = 1'b0;
            if (frame_done) done_cnt++;
            if (recv_ack) ack_seen++;
            if (send_req !== 1'b0) gap_bad++;
        end
    endtask

    function automatic logic [31:0] model(input logic [7:0] c, a, d, k);
        logic [7:0] st, rd;
        st = 8'h00;
        rd = 8'h00;
        if ((c ^ a ^ d) != k)       st = 8'h01;
        else if (c != 1 && c != 2)  st = 8'h02;
        else if (a >= 16)           st = 8'h03;
        if (st == 8'h00) begin
            if (c == 8'h01) m_regs[a[3:0]] = d;
            rd = m_regs[a[3:0]];
        end else if (m_err < 255) begin
            m_err++;
        end
        return {8'h5A, st, rd, st ^ rd};
    endfunction

    initial begin
        int          acks, consec, sreq_cnt, w;
        logic        prev;
        logic [7:0]  c, a, d, k;
        logic [31:0] exp;

        tbl[0]  = '{1, 0, 8'h01, 8'h03, 8'h7E, 8'h7C, 32'h5A007E7E, 8'd0};
        tbl[1]  = '{0, 0, 8'h02, 8'h03, 8'h00, 8'h01, 32'h5A007E7E, 8'd0};
        tbl[2]  = '{0, 0, 8'h01, 8'h03, 8'h11, 8'h00, 32'h5A010001, 8'd1};
        tbl[3]  = '{0, 0, 8'h02, 8'h03, 8'h00, 8'h01, 32'h5A007E7E, 8'd1};
        tbl[4]  = '{1, 0, 8'h05, 8'h02, 8'h00, 8'h07, 32'h5A020002, 8'd1};
        tbl[5]  = '{0, 0, 8'h02, 8'h20, 8'h00, 8'h22, 32'h5A030003, 8'd2};
        tbl[6]  = '{0, 0, 8'h02, 8'h03, 8'h00, 8'h01, 32'h5A000000, 8'd2};
        tbl[7]  = '{1, 2, 8'h02, 8'h00, 8'h00, 8'h02, 32'h5A000000, 8'd0};
        tbl[8]  = '{0, 0, 8'h01, 8'h0F, 8'h33, 8'h3D, 32'h5A003333, 8'd0};
        tbl[9]  = '{0, 0, 8'h02, 8'h10, 8'h00, 8'h12, 32'h5A030003, 8'd1};
        tbl[10] = '{0, 0, 8'h07, 8'h40, 8'h00, 8'h00, 32'h5A010001, 8'd2};
        tbl[11] = '{0, 0, 8'h00, 8'h20, 8'h00, 8'h20, 32'h5A020002, 8'd3};
        tbl[12] = '{0, 0, 8'h02, 8'h0F, 8'h00, 8'h0D, 32'h5A003333, 8'd3};

        reset = 1'b1; recv_req = 1'b0; send_ack = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {29'd0, recv_ack, send_req, frame_done}, 32'd0);
        check("reset_tx", {24'd0, tx_data}, 32'd0);
        check("reset_err", {24'd0, err_count}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            if (tbl[i].noise > 0) send_byte(8'h00);
            if (tbl[i].noise > 1) send_byte(8'hFF);
            run_frame(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].chk);
            get_resp(i % 3);
            check($sformatf("vec%0d_resp", i), resp, tbl[i].resp);
            check($sformatf("vec%0d_err", i), {24'd0, err_count}, {24'd0, tbl[i].err});
            check($sformatf("vec%0d_done", i), done_cnt, 1);
            check($sformatf("vec%0d_gap", i), gap_bad, 0);
        end

        // recv_req held high: acks must alternate, never on consecutive cycles
        @(negedge clk);
        rx_data = 8'h00; recv_req = 1'b1; acks = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (recv_ack) acks++;
            if (recv_ack && prev) consec++;
            prev = recv_ack;
        end
        recv_req = 1'b0;
        @(negedge clk);
        check("hold_acks", acks, 4);
        check("hold_consec", consec, 0);
        check("hold_err", {24'd0, err_count}, 32'd3);

        // inter-byte timeout
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        sreq_cnt = 0;
        for (int i = 0; i < TO - 2; i++) begin
            @(negedge clk);
            if (send_req) sreq_cnt++;
        end
        check("to_early_err", {24'd0, err_count}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (send_req) sreq_cnt++;
        end
        check("to_err", {24'd0, err_count}, 32'd1);
        check("to_no_send", sreq_cnt, 0);
        run_frame(8'h02, 8'h00, 8'h00, 8'h02);
        get_resp(0);
        check("to_next_resp", resp, 32'h5A000000);

        // stalled acks with a request byte waiting in the UART the whole time
        run_frame(8'h01, 8'h07, 8'hC3, 8'hC5);
        rx_data = 8'hA5; recv_req = 1'b1;
        get_resp(100);
        check("slow_resp", resp, 32'h5A00C3C3);
        check("slow_stable", stable_bad, 0);
        check("slow_done", done_cnt, 1);
        check("slow_no_rx", ack_seen, 0);
        w = 0;
        while (recv_ack !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("pending_hdr_ack", {31'd0, recv_ack}, 32'd1);
        recv_req = 1'b0;
        send_byte(8'h02); send_byte(8'h07); send_byte(8'h00); send_byte(8'h05);
        get_resp(0);
        check("pending_resp", resp, 32'h5A00C3C3);

        // reset mid-frame, then mid-response
        run_frame(8'h01, 8'h05, 8'hAA, 8'hAE);
        get_resp(0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h06); send_byte(8'hBB);
        do_reset();
        send_byte(8'hBC);
        run_frame(8'h02, 8'h06, 8'h00, 8'h04);
        get_resp(0);
        check("abort_frame_resp", resp, 32'h5A000000);
        run_frame(8'h02, 8'h05, 8'h00, 8'h07);
        w = 0;
        while (send_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("abort_rsp_started", {31'd0, send_req}, 32'd1);
        do_reset();
        sreq_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (send_req) sreq_cnt++;
        end
        check("abort_rsp_quiet", sreq_cnt, 0);
        check("abort_err", {24'd0, err_count}, 32'd0);

        // err_count saturation
        for (int i = 0; i < 258; i++) begin
            run_frame(8'h01, 8'h00, 8'h00, 8'hFF);
            get_resp(0);
        end
        check("sat_resp", resp, 32'h5A010001);
        check("sat_err", {24'd0, err_count}, 32'h000000FF);

        // randomized frames against the reference model
        do_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_err = 0;
        for (int i = 0; i < 60; i++) begin
            w = $urandom_range(0, 9);
            c = (w < 4) ? 8'h01 : (w < 8) ? 8'h02 : 8'($urandom);
            a = 8'($urandom_range(0, 20));
            d = 8'($urandom);
            k = c ^ a ^ d;
            if ($urandom_range(0, 9) == 0) k = k ^ 8'h55;
            exp = model(c, a, d, k);
            run_frame(c, a, d, k);
            get_resp($urandom_range(0, 3));
            check($sformatf("rand%0d_resp", i), resp, exp);
            check($sformatf("rand%0d_err", i), {24'd0, err_count}, 32'(m_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_responder.md
UART_FRAME_RESPONDER -- requirements
Module: uart_frame_responder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, byte width; all frame fields are DATA_SIZE wide, and only 8 is supported.
REQ-002 SHALL have parameter REG_DEPTH, default 16, number of DATA_SIZE-bit registers in the local register file (power of 2, at most 256).
REQ-003 SHALL have parameter TIMEOUT, default 50000, clk cycles allowed between two bytes of one request frame.
REQ-004 SHALL have port clk, input, 1, single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port recv_req, input, 1, UART receiver byte-available flag; held high until recv_ack.
REQ-007 SHALL have port rx_data, input, DATA_SIZE, received byte; valid while recv_req is high.
REQ-008 SHALL have port recv_ack, output, 1, one-cycle pulse consuming the current rx byte.
REQ-009 SHALL have port send_req, output, 1, transmit request to the UART transmitter.
REQ-010 SHALL have port send_ack, input, 1, transmitter acceptance pulse.
REQ-011 SHALL have port tx_data, output, DATA_SIZE, byte to transmit; stable while send_req is high.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse after the last response byte is acknowledged.
REQ-013 SHALL have port err_count, output, 8, saturating count of rejected frames.

Function
REQ-014 Request frame SHALL be HDR=0xA5, CMD, ADDR, DATA, CHK, with CHK = CMD^ADDR^DATA.
REQ-015 CMD 0x01 SHALL be a write of DATA to reg[ADDR]; CMD 0x02 SHALL be a read, with DATA ignored but still received.
REQ-016 Response frame SHALL be 0x5A, STATUS, RDATA, RCHK, with RCHK = STATUS^RDATA.
REQ-017 STATUS SHALL be 0x00 ok, 0x01 bad CHK, 0x02 unknown CMD, 0x03 ADDR >= REG_DEPTH; checks are applied in that priority order.
REQ-018 RDATA SHALL be reg[ADDR] (post-write value for a write) when STATUS=0x00, and 0x00 otherwise.
REQ-019 The state machine SHALL use the states IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, SEND, WAIT_ACK.
REQ-020 Consuming a byte SHALL assert recv_ack for exactly one cycle, in the cycle after recv_req is seen high, while in IDLE or any GET_ state.
REQ-021 recv_ack SHALL NOT be asserted in the cycle following a recv_ack, so the same byte is never consumed twice.
REQ-022 In IDLE, non-0xA5 bytes SHALL be consumed and discarded without counting an error; 0xA5 SHALL move the FSM to GET_CMD.
REQ-023 GET_CMD, GET_ADDR, GET_DATA and GET_CHK SHALL each latch one byte and advance to the next state; GET_CHK SHALL go to EXEC.
REQ-024 EXEC SHALL last one cycle: it evaluates STATUS, performs the register write only when STATUS=0x00, builds the response, then goes to SEND.
REQ-025 SEND SHALL drive tx_data and raise send_req, then go to WAIT_ACK, holding send_req and tx_data until send_ack is sampled high.
REQ-026 On send_ack, send_req SHALL drop the next cycle and a 2-bit byte index SHALL increment; index 0..2 returns to SEND, and index 3 goes to IDLE with frame_done pulsed.
REQ-027 Back-to-back response bytes SHALL therefore have at least one cycle of send_req low between them.
REQ-028 recv_req SHALL be ignored (no recv_ack) during EXEC, SEND and WAIT_ACK; incoming bytes wait in the UART.
REQ-029 An inter-byte counter SHALL count while in a GET_ state with recv_req low, and SHALL clear on every consumed byte.
REQ-030 When the inter-byte counter reaches TIMEOUT-1, the FSM SHALL go to IDLE, increment err_count, and send no response.
REQ-031 err_count SHALL increment on any nonzero STATUS or timeout, and SHALL saturate at 0xFF.
REQ-032 A send_ack arriving when send_req is low SHALL be ignored.

Reset
REQ-033 While reset is high at a clock edge: state=IDLE, recv_ack=0, send_req=0, tx_data=0x00, frame_done=0, err_count=0x00, counters=0, all registers=0x00.
REQ-034 Reset asserted mid-frame or mid-response SHALL abort immediately; no further send_req is issued and no write is committed.

Verification
REQ-035 Scenario: write frame A5 01 03 7E 7C -> response 5A 00 7E 7E, then a read of ADDR 03 returns RDATA=0x7E.
REQ-036 Scenario: A5 01 03 7E 00 (bad CHK) -> response 5A 01 00 01, reg[3] unchanged, err_count=1.
REQ-037 Scenario: A5 05 02 00 07 -> response 5A 02 00 02; A5 02 20 00 22 -> response 5A 03 00 03; err_count=2.
REQ-038 Scenario: noise bytes 00 FF then a valid read of ADDR 0 -> noise consumed silently, response 5A 00 00 00, err_count=0.
REQ-039 Scenario: A5 01 then no byte for TIMEOUT cycles -> FSM back in IDLE, no send_req, err_count=1; the next valid frame is still answered.
REQ-040 Scenario: send_ack delayed 100 cycles on each response byte -> send_req and tx_data held stable throughout, and frame_done pulses exactly once.
